gf_log_unit: RTL and testbench

GF_LOG_UNIT -- requirements
Module: gf_log_unit

---
 rtl/gf_pkg.sv | 16 +
 rtl/gf_mulx.sv | 24 ++
 rtl/gf_log_unit.sv | 140 ++++++++++++++
 tb/tb_gf_log_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_pkg.sv
// Shared constants and types for the GF(2^M) log/antilog lookup unit.
package gf_pkg;

  localparam int         GF_M    = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef enum logic {
    GF_LOG = 1'b0,
    GF_EXP = 1'b1
  } gf_mode_t;

  typedef logic [0:0] gf_state_t;
  localparam gf_state_t ST_INIT  = 1'b0;
  localparam gf_state_t ST_READY = 1'b1;

endpackage

// File: rtl/gf_mulx.sv
// Combinational multiply-by-alpha (x) modulo the field polynomial POLY.
module gf_mulx
  import gf_pkg::*;
#(
  parameter int         M    = GF_M,
  parameter logic [M:0] POLY = GF_POLY
) (
  input  logic [M-1:0] a,
  output logic [M-1:0] y
);

  genvar gi;
  generate
    for (gi = 0; gi < M; gi++) begin : g_bit
      // Shift left by one; fold the carried-out top bit back in via POLY.
      if (gi == 0) begin : g_lsb
        assign y[gi] = a[M-1] & POLY[gi];
      end else begin : g_hi
        assign y[gi] = a[gi-1] ^ (a[M-1] & POLY[gi]);
      end
    end
  endgenerate

endmodule

// File: rtl/gf_log_unit.sv
// GF(2^M) log lookup unit: builds its tables after reset, then serves a 2-stage pipeline.
// Define GF_ANTILOG_EN to add the exp table and antilog mode (in_mode = 1).
module gf_log_unit
  import gf_pkg::*;
#(
  parameter int         M    = GF_M,
  parameter logic [M:0] POLY = GF_POLY
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_mode,
  input  logic [M-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] out_data,
  output logic         out_err,
  output logic         init_done
);

  localparam int           DEPTH    = 1 << M;
  localparam logic [M-1:0] LAST_IDX = M'(DEPTH - 2);

  gf_state_t    state_reg;
  logic [M-1:0] idx_reg;
  logic [M-1:0] a_reg;
  logic [M-1:0] a_next;
  logic         init_done_reg;
  logic         in_init;
  logic         advance;
  logic         accept;

  logic         s1_valid_reg;
  logic [M-1:0] s1_data_reg;
  logic         s1_is_log;
  logic         s2_valid_reg;
  logic         s2_err_reg;
  logic [M-1:0] rd_sel;

  logic [M-1:0] log_tab [DEPTH];
  logic [M-1:0] log_rd_reg;

  gf_mulx #(.M(M), .POLY(POLY)) u_mulx (
    .a (a_reg),
    .y (a_next)
  );

  assign in_init  = (state_reg == ST_INIT);
  assign advance  = !s2_valid_reg || out_ready;
  assign in_ready = !in_init && advance;
  assign accept   = in_valid && in_ready;

  // Table build: one element per cycle, walking a through alpha^0 .. alpha^(2^M-2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      idx_reg       <= '0;
      a_reg         <= M'(1);
      init_done_reg <= 1'b0;
    end else if (in_init) begin
      idx_reg <= idx_reg + 1'b1;
      a_reg   <= a_next;
      if (idx_reg == LAST_IDX) begin
        state_reg     <= ST_READY;
        init_done_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s2_valid_reg <= 1'b0;
      s2_err_reg   <= 1'b0;
    end else if (advance) begin
      s1_valid_reg <= accept;
      s1_data_reg  <= in_data;
      s2_valid_reg <= s1_valid_reg;
      s2_err_reg   <= s1_valid_reg && s1_is_log && (s1_data_reg == '0);
    end
  end

  // Table RAM is never reset; log_tab[0] is left unwritten and masked by the error path.
  always_ff @(posedge clk) begin
    if (in_init) begin
      log_tab[a_reg] <= idx_reg;
    end
    if (advance) begin
      log_rd_reg <= log_tab[s1_data_reg];
    end
  end

`ifdef GF_ANTILOG_EN
  localparam logic [M-1:0] MAX_EXP = M'(DEPTH - 1);

  gf_mode_t     s1_mode_reg;
  gf_mode_t     s2_mode_reg;
  logic [M-1:0] exp_addr;
  logic [M-1:0] exp_tab [DEPTH];
  logic [M-1:0] exp_rd_reg;

  // Exponent 2^M-1 is the same element as exponent 0.
  assign exp_addr  = (s1_data_reg == MAX_EXP) ? '0 : s1_data_reg;
  assign s1_is_log = (s1_mode_reg == GF_LOG);
  assign rd_sel    = (s2_mode_reg == GF_EXP) ? exp_rd_reg : log_rd_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_mode_reg <= GF_LOG;
      s2_mode_reg <= GF_LOG;
    end else if (advance) begin
      s1_mode_reg <= gf_mode_t'(in_mode);
      s2_mode_reg <= s1_mode_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (in_init) begin
      exp_tab[idx_reg] <= a_reg;
    end
    if (advance) begin
      exp_rd_reg <= exp_tab[exp_addr];
    end
  end
`else
  logic unused_mode;

  assign unused_mode = &{1'b0, in_mode};
  assign s1_is_log   = 1'b1;
  assign rd_sel      = log_rd_reg;
`endif

  assign out_valid = s2_valid_reg;
  assign out_err   = s2_err_reg;
  assign out_data  = (s2_valid_reg && !s2_err_reg) ? rd_sel : '0;
  assign init_done = init_done_reg;

endmodule

// File: tb/tb_gf_log_unit.sv
// Self-checking bench for gf_log_unit (M = 8, POLY = 9'h11D); define GF_ANTILOG_EN to cover antilog mode.
module tb_gf_log_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_mode;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_err;
  logic       init_done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit check_lat = 0;
  bit hold_pending = 0;
  logic [7:0] held_data;
  logic       held_err;

  logic [7:0] exp_ref [255];
  logic [7:0] log_ref [256];
  logic [8:0] exp_q [$];
  int         acc_q [$];

  gf_log_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .init_done (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // Reference: {err, data} from the field definition (powers of 2 reduced by 0x11D).
  function automatic logic [8:0] model(input logic md, input logic [7:0] d);
`ifdef GF_ANTILOG_EN
    if (md) return {1'b0, exp_ref[int'(d) % 255]};
`endif
    if (d == 8'h00) return 9'h100;
    return {1'b0, log_ref[d]};
  endfunction

  task automatic step(input logic v, input logic [7:0] d, input logic md, input logic rdy,
                      input logic [8:0] want, output logic acc);
    logic [8:0] e;
    int a;
    in_valid  = v;
    in_data   = d;
    in_mode   = md;
    out_ready = rdy;
    #1;
    if (hold_pending) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(held_data));
      chk("hold_err", 32'(out_err), 32'(held_err));
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_qsize", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        a = acc_q.pop_front();
        $display("txn cyc=%0d data=%h err=%0d want=%h/%0d", cyc, out_data, out_err, e[7:0], e[8]);
        chk("out_data", 32'(out_data), 32'(e[7:0]));
        chk("out_err", 32'(out_err), 32'(e[8]));
        if (check_lat) chk("latency", 32'(cyc - a), 32'd2);
      end
    end
    hold_pending = out_valid && !out_ready;
    held_data    = out_data;
    held_err     = out_err;
    acc = in_valid && in_ready;
    if (acc) begin
      exp_q.push_back(want);
      acc_q.push_back(cyc);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic send(input logic [7:0] d, input logic md, input logic [8:0] want);
    logic acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      step(1'b1, d, md, 1'b1, want, acc);
      n++;
    end
    if (!acc) chk("send_accept", 32'd0, 32'd1);
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      step(1'b0, 8'h00, 1'b0, 1'b1, 9'h000, acc);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic reset_and_init();
    int n;
    bit ready_seen;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    exp_q.delete();
    acc_q.delete();
    hold_pending = 0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    n = 0;
    ready_seen = 0;
    while (init_done !== 1'b1 && n < 400) begin
      if (in_ready !== 1'b0) ready_seen = 1;
      @(posedge clk);
      @(negedge clk);
      n++;
      cyc++;
    end
    chk("init_cycles", 32'(n), 32'd255);
    chk("in_ready_during_init", 32'(ready_seen), 32'd0);
    chk("in_ready_after_init", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic acc;
    logic [7:0] req [3];
    logic [7:0] d;
    logic md;
    int k;
    int p;

    p = 1;
    for (int i = 0; i < 255; i++) begin
      exp_ref[i] = 8'(p);
      log_ref[p] = 8'(i);
      p = p * 2;
      if (p >= 256) p = p ^ 'h11D;
    end

    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    reset_and_init();

    // Back-to-back log requests with known answers, exact 2-cycle latency.
    check_lat = 1;
    send(8'h01, 1'b0, 9'h000);
    send(8'h02, 1'b0, 9'h001);
    send(8'h80, 1'b0, 9'h007);
    send(8'h1D, 1'b0, 9'h008);
    drain();

    // Log of zero flags an error, the next request clears it.
    send(8'h00, 1'b0, 9'h100);
    send(8'h02, 1'b0, 9'h001);
    drain();

`ifdef GF_ANTILOG_EN
    send(8'h08, 1'b1, 9'h01D);
    send(8'hFF, 1'b1, 9'h001);
    drain();
    for (int x = 1; x < 256; x++) send(8'(x), 1'b0, model(1'b0, 8'(x)));
    drain();
    for (int x = 1; x < 256; x++) send(log_ref[x], 1'b1, {1'b0, 8'(x)});
    drain();
`else
    // in_mode must be ignored: every request is a log lookup.
    send(8'h80, 1'b1, 9'h007);
    send(8'h00, 1'b1, 9'h100);
    drain();
`endif

    // Stall with three requests offered: only two fit, outputs hold.
    check_lat = 0;
    req[0] = 8'h03; req[1] = 8'h00; req[2] = 8'hC7;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, req[k], 1'b0, 1'b0, model(1'b0, req[k]), acc);
      if (acc) k++;
    end
    chk("stall_accepts", 32'(k), 32'd2);
    for (int c = 0; c < 10 && k < 3; c++) begin
      step(1'b1, req[k], 1'b0, 1'b1, model(1'b0, req[k]), acc);
      if (acc) k++;
    end
    chk("stall_release_accepts", 32'(k), 32'd3);
    drain();

    // Randomized traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      d  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      if ($urandom_range(0, 7) == 0) d = 8'hFF;
      md = 1'($urandom);
      step(1'($urandom_range(0, 3) != 0), d, md, 1'($urandom_range(0, 3) != 0), model(md, d), acc);
    end
    drain();

    // Reset in the middle of the table build.
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midinit_init_done", 32'(init_done), 32'd0);
    chk("midinit_in_ready", 32'(in_ready), 32'd0);
    reset_and_init();
    check_lat = 1;
    send(8'h1D, 1'b0, 9'h008);
    send(8'h80, 1'b0, 9'h007);
    drain();

    // Reset during a stalled transfer: the held result must vanish at once.
    check_lat = 0;
    step(1'b1, 8'h55, 1'b0, 1'b0, model(1'b0, 8'h55), acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, acc);
    step(1'b0, 8'h00, 1'b0, 1'b0, 9'h000, acc);
    chk("stalled_valid_before_rst", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_out_data", 32'(out_data), 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd0);
    reset_and_init();
    check_lat = 1;
    send(8'h02, 1'b0, 9'h001);
    send(8'h00, 1'b0, 9'h100);
    send(8'h01, 1'b0, 9'h000);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
